// File: rtl/core_pkg.sv
// Shared types and constants for the core_seq instruction sequencer.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        FWAIT  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        HC_NONE    = 2'b00,
        HC_EBREAK  = 2'b01,
        HC_ILLEGAL = 2'b10,
        HC_TIMEOUT = 2'b11
    } halt_cause_t;

    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;

    function automatic logic opcode_supported(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_JAL,
            OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Branches and stores have no destination; writes to x0 are dropped.
    function automatic logic writes_rd(input logic [31:0] ins);
        return (ins[6:0] != OP_BRANCH) && (ins[6:0] != OP_STORE) && (ins[11:7] != 5'd0);
    endfunction

endpackage

// File: rtl/core_seq.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with halt detection.
module core_seq
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int unsigned EXU_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    output logic        exu_start,
    input  logic        exu_done,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] retired
);

    localparam int unsigned TW = (EXU_TIMEOUT > 1) ? $clog2(EXU_TIMEOUT) : 1;

    state_t        r_state;
    state_t        w_next;
    halt_cause_t   r_cause;
    halt_cause_t   w_cause_next;
    logic          r_started;
    logic [31:0]   r_pc;
    logic [31:0]   r_inst;
    logic [31:0]   r_retired;
    logic [31:0]   r_br_target;
    logic          r_br_taken;
    logic [TW-1:0] r_tmo;
    logic          w_dec_ok;
    logic          w_tmo_last;

    assign w_dec_ok   = (r_inst != EBREAK) && opcode_supported(r_inst[6:0]);
    assign w_tmo_last = (r_tmo == TW'(EXU_TIMEOUT - 1));

    // r_started keeps the request low until the first edge after reset release.
    assign imem_req_valid = (r_state == FETCH) && r_started;
    assign exu_start      = (r_state == DECODE) && w_dec_ok;
    assign rf_wen         = (r_state == WB) && writes_rd(r_inst);
    assign halted         = (r_state == HALT);
    assign halt_cause     = r_cause;
    assign imem_addr      = r_pc;
    assign pc             = r_pc;
    assign inst           = r_inst;
    assign retired        = r_retired;

    always_comb begin
        w_next       = r_state;
        w_cause_next = r_cause;
        case (r_state)
            FETCH: begin
                if (imem_req_valid && imem_req_ready) w_next = FWAIT;
            end
            FWAIT: begin
                if (imem_rsp_valid) w_next = DECODE;
            end
            DECODE: begin
                if (r_inst == EBREAK) begin
                    w_next       = HALT;
                    w_cause_next = HC_EBREAK;
                end else if (!opcode_supported(r_inst[6:0])) begin
                    w_next       = HALT;
                    w_cause_next = HC_ILLEGAL;
                end else begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                if (exu_done) begin
                    w_next = WB;
                end else if (w_tmo_last) begin
                    w_next       = HALT;
                    w_cause_next = HC_TIMEOUT;
                end
            end
            WB:      w_next = FETCH;
            HALT:    w_next = HALT;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FETCH;
            r_cause     <= HC_NONE;
            r_started   <= 1'b0;
            r_pc        <= RESET_PC;
            r_inst      <= '0;
            r_retired   <= '0;
            r_br_target <= '0;
            r_br_taken  <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_started <= 1'b1;
            r_state   <= w_next;
            r_cause   <= w_cause_next;

            if (r_state == FWAIT && imem_rsp_valid) begin
                r_inst <= imem_rsp_data;
            end

            if (r_state == EXEC) begin
                if (exu_done) begin
                    r_br_taken  <= br_taken;
                    r_br_target <= {br_target[31:2], 2'b00};
                    r_tmo       <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else begin
                r_tmo <= '0;
            end

            if (r_state == WB) begin
                r_pc      <= r_br_taken ? r_br_target : r_pc + 32'd4;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: vector table plus scoreboard and corner-case sequences.
module tb_core_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] ADDI   = 32'h0010_0093;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic [31:0] inst;
    logic        exu_start;
    logic        exu_done  = 1'b0;
    logic        br_taken  = 1'b0;
    logic [31:0] br_target = '0;
    logic        rf_wen;
    logic [31:0] pc;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] retired;

    always #5 clk = ~clk;

    core_seq #(.RESET_PC(RST_PC), .EXU_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst(inst), .exu_start(exu_start),
        .exu_done(exu_done), .br_taken(br_taken), .br_target(br_target),
        .rf_wen(rf_wen), .pc(pc), .halted(halted), .halt_cause(halt_cause),
        .retired(retired)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wen;
        logic [31:0] pc;
        logic [31:0] ret;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] ins;
        int          ready_dly;
        int          done_dly;
        logic        done_in_dec;
        logic        taken;
        logic [31:0] target;
        logic        exp_wen;
    } vec_t;
    vec_t vecs[10];

    logic [31:0] model_pc;
    logic [31:0] model_ret;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Retirement monitor: each retired-count change pops one expected record.
    initial begin
        logic [31:0] last_ret;
        int          wen_cnt;
        exp_t        e;
        last_ret = '0;
        wen_cnt  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                last_ret = '0;
                wen_cnt  = 0;
            end else begin
                if (retired != last_ret) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_retire", retired, last_ret);
                    end else begin
                        e = sb.pop_front();
                        check("sb_pc", pc, e.pc);
                        check("sb_retired", retired, e.ret);
                        check("sb_wen_pulses", 32'(wen_cnt), {31'd0, e.wen});
                    end
                    wen_cnt = 0;
                end
                if (rf_wen) wen_cnt++;
                last_ret = retired;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        exu_done = 1'b0;
        br_taken = 1'b0;
        sb.delete();
        model_pc  = RST_PC;
        model_ret = '0;
        tick();
        tick();
        check("rst_pc", pc, RST_PC);
        check("rst_inst", inst, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cause", {30'd0, halt_cause}, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("rel_req_valid_low", {31'd0, imem_req_valid}, 32'd0);
        tick();
        check("rel_req_valid_high", {31'd0, imem_req_valid}, 32'd1);
    endtask

    // Starts in FETCH with the request presented; ends in DECODE.
    task automatic fetch_to_decode(input logic [31:0] ins);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ins;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
    endtask

    task automatic do_instr(input vec_t v, output int wb_cycle);
        int   c;
        exp_t e;
        c = 1;
        for (int i = 0; i < v.ready_dly; i++) begin
            check("stall_valid", {31'd0, imem_req_valid}, 32'd1);
            check("stall_addr", imem_addr, model_pc);
            tick();
            c++;
        end
        check("fetch_valid", {31'd0, imem_req_valid}, 32'd1);
        check("fetch_addr", imem_addr, model_pc);
        imem_req_ready = 1'b1;
        tick();
        c++;
        imem_req_ready = 1'b0;
        check("fwait_valid_low", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = v.ins;
        model_pc  = v.taken ? (v.target & 32'hFFFF_FFFC) : model_pc + 32'd4;
        model_ret = model_ret + 32'd1;
        e.wen = v.exp_wen;
        e.pc  = model_pc;
        e.ret = model_ret;
        sb.push_back(e);
        tick();
        c++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        check("decode_start", {31'd0, exu_start}, 32'd1);
        check("decode_inst", inst, v.ins);
        exu_done = v.done_in_dec;
        tick();
        c++;
        exu_done = 1'b0;
        check("exec_start_low", {31'd0, exu_start}, 32'd0);
        for (int i = 0; i < v.done_dly; i++) begin
            tick();
            c++;
        end
        exu_done  = 1'b1;
        br_taken  = v.taken;
        br_target = v.target;
        tick();
        c++;
        exu_done  = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        check("wb_rf_wen", {31'd0, rf_wen}, {31'd0, v.exp_wen});
        wb_cycle = c;
        tick();
        check("next_fetch_valid", {31'd0, imem_req_valid}, 32'd1);
        check("next_fetch_addr", imem_addr, model_pc);
    endtask

    initial begin
        int wbc;
        vecs[0] = '{ADDI,          0, 0,  1'b0, 1'b0, 32'h0,         1'b1};
        vecs[1] = '{32'h0020_81B3, 3, 0,  1'b0, 1'b0, 32'h0,         1'b1};
        vecs[2] = '{32'h0000_0063, 0, 0,  1'b0, 1'b1, 32'h8000_0102, 1'b0};
        vecs[3] = '{32'h0020_A023, 1, 1,  1'b0, 1'b0, 32'h0,         1'b0};
        vecs[4] = '{32'h0000_0037, 0, 0,  1'b0, 1'b0, 32'h0,         1'b0};
        vecs[5] = '{32'h1234_52B7, 0, 2,  1'b1, 1'b0, 32'h0,         1'b1};
        vecs[6] = '{32'h0000_0317, 0, 15, 1'b0, 1'b0, 32'h0,         1'b1};
        vecs[7] = '{32'h0080_00EF, 2, 0,  1'b0, 1'b1, 32'h8000_0203, 1'b1};
        vecs[8] = '{32'h0000_8067, 0, 1,  1'b0, 1'b1, 32'h8000_0000, 1'b0};
        vecs[9] = '{32'h0000_2103, 0, 3,  1'b1, 1'b0, 32'h0,         1'b1};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_instr(vecs[i], wbc);
            if (i == 0) check("first_wb_cycle", 32'(wbc), 32'd5);
        end
        tick();
        check("seq_pc", pc, model_pc);
        check("seq_retired", retired, 32'd10);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // ebreak halts with no retirement and no further fetch
        fetch_to_decode(32'h0010_0073);
        check("ebreak_no_start", {31'd0, exu_start}, 32'd0);
        tick();
        check("ebreak_halted", {31'd0, halted}, 32'd1);
        check("ebreak_cause", {30'd0, halt_cause}, 32'd1);
        check("ebreak_retired", retired, model_ret);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        exu_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_outputs", {29'd0, imem_req_valid, exu_start, rf_wen}, 32'd0);
            check("halt_pc", pc, model_pc);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        exu_done = 1'b0;
        check("halt_retired", retired, model_ret);

        // illegal opcode
        do_reset();
        fetch_to_decode(32'h0000_007F);
        check("illegal_no_start", {31'd0, exu_start}, 32'd0);
        tick();
        check("illegal_halted", {31'd0, halted}, 32'd1);
        check("illegal_cause", {30'd0, halt_cause}, 32'd2);

        // EXU timeout after 16 EXEC cycles
        do_reset();
        fetch_to_decode(ADDI);
        tick();
        for (int i = 0; i < 15; i++) begin
            check("tmo_not_yet", {31'd0, halted}, 32'd0);
            tick();
        end
        check("tmo_cycle16_running", {31'd0, halted}, 32'd0);
        tick();
        check("tmo_halted", {31'd0, halted}, 32'd1);
        check("tmo_cause", {30'd0, halt_cause}, 32'd3);
        check("tmo_retired", retired, 32'd0);
        check("tmo_pc", pc, RST_PC);

        // stray response in FETCH, then reset during EXEC with late done
        do_reset();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ADDI;
        tick();
        tick();
        imem_rsp_valid = 1'b0;
        check("stray_rsp_valid_held", {31'd0, imem_req_valid}, 32'd1);
        check("stray_rsp_inst", inst, 32'd0);
        fetch_to_decode(ADDI);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("mid_exec_rst_pc", pc, RST_PC);
        check("mid_exec_rst_valid", {31'd0, imem_req_valid}, 32'd0);
        tick();
        rst = 1'b1;
        exu_done = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_007F;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("late_done_no_wen", {31'd0, rf_wen}, 32'd0);
            check("late_done_fetch", {31'd0, imem_req_valid}, 32'd1);
        end
        exu_done = 1'b0;
        imem_rsp_valid = 1'b0;
        check("late_done_retired", retired, 32'd0);
        check("late_done_pc", pc, RST_PC);
        check("late_done_halted", {31'd0, halted}, 32'd0);
        check("late_inst_ignored", inst, 32'd0);
        check("sb_final", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter EXU_TIMEOUT, default 16, giving the maximum cycles to wait for exu_done.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  instruction memory accepts the request.
REQ-007 imem_addr  out  32  fetch address; equals pc.
REQ-008 imem_rsp_valid  in  1  fetched instruction valid.
REQ-009 imem_rsp_data  in  32  fetched instruction word.
REQ-010 inst  out  32  latched instruction presented to the decoder.
REQ-011 exu_start  out  1  one-cycle pulse that starts execution.
REQ-012 exu_done  in  1  execution result valid.
REQ-013 br_taken  in  1  redirect request; sampled with exu_done.
REQ-014 br_target  in  32  redirect address; sampled with exu_done.
REQ-015 rf_wen  out  1  register-file write enable; writeback gate.
REQ-016 pc  out  32  current program counter.
REQ-017 halted  out  1  core stopped.
REQ-018 halt_cause  out  2  00 none, 01 ebreak, 10 illegal opcode, 11 EXU timeout.
REQ-019 retired  out  32  count of instructions retired.

Function
REQ-020 FSM states SHALL be: FETCH, FWAIT, DECODE, EXEC, WB, HALT.
REQ-021 FETCH: imem_req_valid=1; go to FWAIT in the same cycle that imem_req_ready=1; otherwise hold, keeping imem_addr stable.
REQ-022 FWAIT: imem_req_valid=0; when imem_rsp_valid=1, latch imem_rsp_data into inst and go to DECODE.
REQ-023 An imem_rsp_valid seen in any state other than FWAIT SHALL be ignored.
REQ-024 DECODE, inst==32'h0010_0073 (ebreak): go to HALT with cause 01; no writeback; retired unchanged.
REQ-025 DECODE, inst[6:0] not in the supported set {0010011, 0110011, 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011}: go to HALT with cause 10.
REQ-026 DECODE, otherwise: assert exu_start for exactly one cycle and go to EXEC.
REQ-027 EXEC: wait for exu_done=1, then go to WB; an exu_done in the same cycle as exu_start SHALL NOT be accepted.
REQ-028 EXEC: if exu_done has not arrived after EXU_TIMEOUT cycles, go to HALT with cause 11.
REQ-029 WB: rf_wen=1 for exactly one cycle, but only if inst[6:0] is not 1100011 (branch) or 0100011 (store) and inst[11:7]!=0.
REQ-030 WB: pc <= br_target if br_taken was sampled as 1, else pc+4 (modulo 2^32); retired increments by 1, wrapping at 2^32; go to FETCH.
REQ-031 A br_target with bits [1:0] != 00 SHALL be forced to 00 in those bits.
REQ-032 Minimum latency per instruction, with ready/rsp/done all asserted immediately, SHALL be 5 cycles (FETCH, FWAIT, DECODE, EXEC, WB).
REQ-033 HALT is terminal until reset: halted=1; all request, start and wen outputs are 0; pc and retired are frozen.
REQ-034 imem_req_valid, exu_start and rf_wen SHALL be registered-state decodes (Moore); none may depend combinationally on an input.

Reset
REQ-035 While rst=0: state=FETCH, pc=RESET_PC, inst=0, retired=0, halted=0, halt_cause=00, timeout counter=0.
REQ-036 Reset asserted in any state (including mid-fetch or mid-EXEC) SHALL abort the operation; a late imem_rsp_valid or exu_done arriving after reset release SHALL be ignored per REQ-023 and REQ-027.
REQ-037 imem_req_valid SHALL first rise on the first clk edge after rst is released.

Structure
REQ-038 State encoding, the halt_cause codes, the opcode constants and the EBREAK constant SHALL live in the shared package core_pkg.
REQ-039 No sub-module: a single FSM, a pc register and two counters (retired, timeout).

Verification
REQ-040 Reset release, ready=1 immediately, rsp 32'h0010_0093 (addi) after 1 cycle, done after 1 cycle -> rf_wen pulse in cycle 5; pc=0x8000_0004; retired=1.
REQ-041 imem_req_ready held low 3 cycles -> imem_addr is stable and imem_req_valid=1 for 4 cycles; no state advance.
REQ-042 Branch inst 32'h0000_0063 with br_taken=1, br_target=0x8000_0102 -> rf_wen=0; pc=0x8000_0100.
REQ-043 inst 32'h0010_0073 -> halted=1, halt_cause=01, retired unchanged; no further imem_req_valid.
REQ-044 exu_done withheld 16 cycles -> halt_cause=11; opcode 7'b1111111 -> halt_cause=10.
REQ-045 rst pulled low during EXEC, then exu_done after release -> state=FETCH, pc=RESET_PC, no rf_wen.
